// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 3-sample majority vote and valid/ready byte output
module uart_rx #(
  parameter int CLKS_PER_BIT = 15
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  input  logic       data_ready_i,
  output logic       framing_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_sync1;
  logic            r_rx_s;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_bitn;
  logic            r_s0;
  logic            r_s1;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            r_ovr;

  logic            w_maj;
  logic            w_decide;
  logic            w_wrap;
  logic            w_stop_ok;
  logic            w_stop_bad;

  // The third sample is the live synchronised line, so the vote resolves in the cnt=MID+1 cycle.
  assign w_maj      = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_decide   = (r_state == S_START || r_state == S_DATA || r_state == S_STOP) && (r_cnt == CNT_DEC);
  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_stop_ok  = (r_state == S_STOP) && w_decide && w_maj;
  assign w_stop_bad = (r_state == S_STOP) && w_decide && !w_maj;

  // Two-flop synchroniser for the asynchronous serial line; idles high out of reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_rx_s  <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: the stop decision returns to IDLE at once so back-to-back frames need no gap.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_state_next = S_START;
      end
      S_START: begin
        if (w_decide && w_maj) w_state_next = S_IDLE;
        else if (w_wrap)       w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_wrap && r_bitn == 4'd8) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_decide) w_state_next = w_maj ? S_IDLE : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (r_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bit-period and bit-index counters; the start-detect cycle counts as cnt=0 of bit 0.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt  <= '0;
      r_bitn <= '0;
    end else if (w_state_next == S_IDLE || w_state_next == S_WAIT_IDLE) begin
      r_cnt  <= '0;
      r_bitn <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt  <= CW'(1);
      r_bitn <= '0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_bitn <= r_bitn + 4'd1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Capture the two samples that precede the vote cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_cnt == CNT_S0) r_s0 <= r_rx_s;
      if (r_cnt == CNT_S1) r_s1 <= r_rx_s;
    end
  end

  // Data bits enter from the MSB side so the first bit on the wire lands in bit 0.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_shift <= '0;
    end else if (r_state == S_DATA && w_decide) begin
      r_shift <= {w_maj, r_shift[7:1]};
    end
  end

  // Output byte, handshake and error pulses; a byte landing during acceptance is not an overrun.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_ovr  <= w_stop_ok && r_valid && !data_ready_i;
      if (w_stop_ok) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && data_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o        = r_data;
  assign data_valid_o  = r_valid;
  assign framing_err_o = r_ferr;
  assign overrun_o     = r_ovr;
  assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized frame-level bench for uart_rx with a cycle-stamped event model
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB  = 15;
  localparam int MIDV = CPB / 2;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       rx_i = 1'b1;
  logic       data_ready_i = 1'b1;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       framing_err_o;
  logic       overrun_o;
  logic       busy_o;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .rx_i          (rx_i),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready_i),
    .framing_err_o (framing_err_o),
    .overrun_o     (overrun_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // kind: 0 false start, 1 good byte, 2 framing error
  typedef struct {
    int         t0;
    int         kind;
    logic [7:0] data;
    int         ev;
    int         bend;
  } frame_t;

  frame_t q[$];

  int checks = 0;
  int errors = 0;

  int rises = 0, hi_cycles = 0, nferr = 0, novr = 0;
  int rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  int last_t0 = 0;
  int ready_mode = 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Wire-level sender: one start, 8 data LSB first, one stop; optional one-cycle glitch.
  task automatic send(input logic [7:0] b, input logic stop, input int gbit, input int gcnt, input int extra);
    frame_t f;
    logic [9:0] bits;
    int k;
    k = cyc;
    bits = {stop, b, 1'b0};
    f.t0   = k + 2;
    f.data = b;
    f.kind = stop ? 1 : 2;
    f.ev   = f.t0 + 9 * CPB + MIDV + 2;
    f.bend = stop ? f.t0 + 9 * CPB + MIDV + 1 : f.t0 + (10 + extra) * CPB;
    q.push_back(f);
    last_t0 = f.t0;
    for (int n = 0; n < 10; n++) begin
      for (int j = 0; j < CPB; j++) begin
        rx_i = bits[n] ^ ((n == gbit) && (j == gcnt));
        tick();
      end
    end
    if (!stop) begin
      rx_i = 1'b0;
      repeat (extra * CPB) tick();
      rx_i = 1'b1;
      tick();
      tick();
    end
    rx_i = 1'b1;
  endtask

  // Ready driver.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       data_ready_i = 1'b0;
        1:       data_ready_i = 1'b1;
        default: data_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Model and per-cycle compare.
  initial begin : compare
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       prev_valid;
    logic       prev_ready;
    logic       ev_good;
    logic       ev_bad;
    logic       exp_busy;
    logic       exp_ovr;
    logic [7:0] ev_data;
    logic       last_v;
    exp_valid = 1'b0; exp_data = 8'h00; prev_valid = 1'b0; prev_ready = 1'b0; last_v = 1'b0;
    ev_data = 8'h00;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        q.delete();
        exp_valid = 1'b0; exp_data = 8'h00; prev_valid = 1'b0; prev_ready = 1'b0;
        chk("rst_valid", data_valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ferr", framing_err_o, 0);
        chk("rst_ovr", overrun_o, 0);
        chk("rst_busy", busy_o, 0);
      end else begin
        while (q.size() > 0 && ((q[0].bend > q[0].ev) ? q[0].bend : q[0].ev) < cyc)
          void'(q.pop_front());
        ev_good = 1'b0; ev_bad = 1'b0; exp_busy = 1'b0;
        for (int i = 0; i < q.size() && i < 2; i++) begin
          if (cyc > q[i].t0 && cyc <= q[i].bend) exp_busy = 1'b1;
          if (q[i].ev == cyc && q[i].kind == 1) begin ev_good = 1'b1; ev_data = q[i].data; end
          if (q[i].ev == cyc && q[i].kind == 2) ev_bad = 1'b1;
        end
        exp_ovr = 1'b0;
        if (ev_good) begin
          exp_ovr   = prev_valid && !prev_ready;
          exp_valid = 1'b1;
          exp_data  = ev_data;
        end else if (prev_valid && prev_ready) begin
          exp_valid = 1'b0;
        end
        chk("valid", data_valid_o, exp_valid);
        chk("data", data_o, exp_data);
        chk("ferr", framing_err_o, ev_bad);
        chk("ovr", overrun_o, exp_ovr);
        chk("busy", busy_o, exp_busy);
        prev_valid = exp_valid;
        prev_ready = data_ready_i;
      end
      if (data_valid_o && !last_v) begin
        rises++;
        rise_cyc = cyc;
        rise_data = data_o;
      end
      if (data_valid_o) hi_cycles++;
      if (framing_err_o) nferr++;
      if (overrun_o) novr++;
      last_v = data_valid_o;
    end
  end

  initial begin : main
    int r0, h0, f0, o0, k;
    frame_t f;
    logic [7:0] fb;
    logic [7:0] b;
    logic st;
    int gb, gc, ex, gap;

    reset_ni = 1'b0;
    rx_i = 1'b1;
    ready_mode = 1;
    repeat (3) tick();
    reset_ni = 1'b1;
    repeat (3) tick();

    // Single byte 0x55 with ready held high.
    r0 = rises; h0 = hi_cycles; f0 = nferr; o0 = novr;
    send(8'h55, 1'b1, -1, -1, 0);
    repeat (20) tick();
    chk("single_rise_ofs", rise_cyc - last_t0, 144);
    chk("single_data", rise_data, 8'h55);
    chk("single_rises", rises - r0, 1);
    chk("single_hi_cycles", hi_cycles - h0, 1);
    chk("single_no_err", (nferr - f0) + (novr - o0), 0);

    // False start: three low cycles.
    r0 = rises; f0 = nferr;
    k = cyc;
    f.t0 = k + 2; f.kind = 0; f.data = 8'h00; f.bend = k + 2 + MIDV + 1; f.ev = f.bend;
    q.push_back(f);
    rx_i = 1'b0;
    repeat (3) tick();
    rx_i = 1'b1;
    while (cyc < k + 2 + 8) tick();
    chk("fs_busy_t0p8", busy_o, 1);
    tick();
    chk("fs_idle_t0p9", busy_o, 0);
    repeat (20) tick();
    chk("fs_no_valid", rises - r0, 0);
    chk("fs_no_ferr", nferr - f0, 0);

    // Glitch on data bit 2 centre sample.
    send(8'hA3, 1'b1, 3, MIDV, 0);
    repeat (20) tick();
    chk("glitch_data", rise_data, 8'hA3);

    // Framing error then 40-bit break, then a clean byte.
    r0 = rises; f0 = nferr;
    send(8'h3C, 1'b0, -1, -1, 40);
    repeat (5) tick();
    chk("break_one_ferr", nferr - f0, 1);
    chk("break_no_valid", rises - r0, 0);
    send(8'h81, 1'b1, -1, -1, 0);
    repeat (20) tick();
    chk("after_break_rises", rises - r0, 1);
    chk("after_break_data", rise_data, 8'h81);

    // Overrun with ready low.
    ready_mode = 0;
    o0 = novr;
    send(8'h11, 1'b1, -1, -1, 0);
    send(8'h22, 1'b1, -1, -1, 0);
    repeat (10) tick();
    chk("ovr_count", novr - o0, 1);
    chk("ovr_data", data_o, 8'h22);
    chk("ovr_valid", data_valid_o, 1);
    ready_mode = 1;
    repeat (3) tick();
    chk("ovr_cleared", data_valid_o, 0);

    // Reset during data bit 4 of 0xF0, then 0x0F.
    r0 = rises;
    fb = 8'hF0;
    k = cyc;
    f.t0 = k + 2; f.kind = 1; f.data = fb; f.ev = f.t0 + 9 * CPB + MIDV + 2; f.bend = f.ev - 1;
    q.push_back(f);
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int n = 0; n < 4; n++) begin
      rx_i = fb[n];
      repeat (CPB) tick();
    end
    rx_i = fb[4];
    repeat (MIDV) tick();
    reset_ni = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_valid", data_valid_o, 0);
    repeat (3) tick();
    rx_i = 1'b1;
    tick();
    reset_ni = 1'b1;
    repeat (5) tick();
    send(8'h0F, 1'b1, -1, -1, 0);
    repeat (20) tick();
    chk("midrst_rises", rises - r0, 1);
    chk("midrst_data", rise_data, 8'h0F);

    // Randomized frames, glitches, framing errors and ready patterns.
    ready_mode = 2;
    for (int it = 0; it < 40; it++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 1) == 1) begin
        gb = $urandom_range(1, 9);
        gc = $urandom_range(MIDV - 1, MIDV + 1);
      end else begin
        gb = -1;
        gc = -1;
      end
      ex = st ? 0 : $urandom_range(0, 3);
      send(b, st, gb, gc, ex);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
      repeat (gap) tick();
    end
    ready_mode = 1;
    repeat (200) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
